// File: rtl/vector_alu_seq.sv
// Sequential LANES x S-bit vector ALU with a start/busy/done handshake, registered
// results and a restoring divider shared by all lanes.
module vector_alu_seq #(
    parameter  int LANES = 6,
    parameter  int S     = 32,
    localparam int V     = LANES * S
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [1:0]       sel,
    input  logic [V-1:0]     A,
    input  logic [V-1:0]     B,
    output logic             busy,
    output logic             done,
    output logic [V-1:0]     C,
    output logic             flagZ,
    output logic [LANES-1:0] lane_zero,
    output logic             div0
);

    localparam int CW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DIV,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic                      op_reg;
    logic [1:0]                sel_reg;
    logic [V-1:0]              a_reg;
    logic [V-1:0]              b_reg;
    logic [CW-1:0]             count;
    logic                      div_init;
    logic [LANES-1:0][S-1:0]   rem_reg;
    logic [LANES-1:0][S-1:0]   quo_reg;
    logic [LANES-1:0][S-1:0]   rem_next;
    logic [LANES-1:0][S-1:0]   quo_next;
    logic [S:0]                trial [LANES];
    logic [V-1:0]              exec_c;
    logic [V-1:0]              div_c;
    logic [V-1:0]              new_c;
    logic [LANES-1:0]          new_lane_zero;
    logic [S-1:0]              b0;
    logic                      start_is_div;
    logic                      last_step;

    assign b0           = b_reg[S-1:0];
    assign start_is_div = op ? (sel == 2'b01) : (sel == 2'b11);
    assign last_step    = (state == DIV) && !div_init && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = start_is_div ? DIV : EXEC;
                end
            end
            EXEC: next_state = DONE;
            DIV: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Single-cycle ops; divides never come through here, their lanes stay 0.
    always_comb begin
        exec_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if (op_reg) begin
                case (sel_reg)
                    2'b00:   exec_c[i*S +: S] = a_reg[i*S +: S] * b0;
                    2'b10:   exec_c[i*S +: S] = a_reg[i*S +: S] + b_reg[i*S +: S];
                    2'b11:   exec_c[i*S +: S] = a_reg[i*S +: S] - b_reg[i*S +: S];
                    default: exec_c[i*S +: S] = '0;
                endcase
            end else if (i == 0) begin
                case (sel_reg)
                    2'b00:   exec_c[S-1:0] = a_reg[S-1:0] + b0;
                    2'b01:   exec_c[S-1:0] = a_reg[S-1:0] - b0;
                    2'b10:   exec_c[S-1:0] = a_reg[S-1:0] * b0;
                    default: exec_c[S-1:0] = '0;
                endcase
            end
        end
    end

    // One restoring step per lane; a zero divisor always subtracts, giving all-ones.
    always_comb begin
        div_c = '0;
        for (int i = 0; i < LANES; i++) begin
            trial[i] = {rem_reg[i], quo_reg[i][S-1]};
            if (trial[i] >= {1'b0, b0}) begin
                rem_next[i] = trial[i][S-1:0] - b0;
                quo_next[i] = {quo_reg[i][S-2:0], 1'b1};
            end else begin
                rem_next[i] = trial[i][S-1:0];
                quo_next[i] = {quo_reg[i][S-2:0], 1'b0};
            end
            if (op_reg || (i == 0)) begin
                div_c[i*S +: S] = quo_next[i];
            end
        end
    end

    always_comb begin
        new_c = (state == DIV) ? div_c : exec_c;
        for (int i = 0; i < LANES; i++) begin
            new_lane_zero[i] = (new_c[i*S +: S] == '0);
        end
    end

    // The first DIV cycle loads the dividend; the counter then walks S-1 down to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg    <= 1'b0;
            sel_reg   <= 2'b00;
            a_reg     <= '0;
            b_reg     <= '0;
            count     <= '0;
            div_init  <= 1'b0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            C         <= '0;
            flagZ     <= 1'b1;
            lane_zero <= '1;
            div0      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_reg   <= op;
                        sel_reg  <= sel;
                        a_reg    <= A;
                        b_reg    <= B;
                        div0     <= 1'b0;
                        count    <= CW'(S - 1);
                        div_init <= 1'b1;
                    end
                end
                EXEC: begin
                    C         <= new_c;
                    flagZ     <= (new_c == '0);
                    lane_zero <= new_lane_zero;
                end
                DIV: begin
                    if (div_init) begin
                        rem_reg  <= '0;
                        quo_reg  <= a_reg;
                        div_init <= 1'b0;
                    end else begin
                        rem_reg <= rem_next;
                        quo_reg <= quo_next;
                        count   <= count - CW'(1);
                        if (count == '0) begin
                            C         <= new_c;
                            flagZ     <= (new_c == '0);
                            lane_zero <= new_lane_zero;
                            div0      <= (b0 == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_alu_seq.sv
// Randomised and directed bench for vector_alu_seq against a lane-by-lane
// arithmetic reference model.
module tb_vector_alu_seq;

    localparam int LANES = 6;
    localparam int S     = 32;
    localparam int V     = LANES * S;

    logic             clk;
    logic             rst;
    logic             start;
    logic             op;
    logic [1:0]       sel;
    logic [V-1:0]     A;
    logic [V-1:0]     B;
    logic             busy;
    logic             done;
    logic [V-1:0]     C;
    logic             flagZ;
    logic [LANES-1:0] lane_zero;
    logic             div0;

    int compare_count  = 0;
    int mismatch_count = 0;

    vector_alu_seq #(.LANES(LANES), .S(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .sel       (sel),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .C         (C),
        .flagZ     (flagZ),
        .lane_zero (lane_zero),
        .div0      (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [V-1:0] actual, input logic [V-1:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [V-1:0] randVec();
        logic [V-1:0] r;
        for (int i = 0; i < LANES; i++) begin
            r[i*S +: S] = $urandom;
        end
        return r;
    endfunction

    // Reference: each lane from plain 64-bit arithmetic, truncated to S bits.
    function automatic logic [V-1:0] modelResult(input logic o, input logic [1:0] s,
                                                 input logic [V-1:0] a, input logic [V-1:0] b);
        logic [V-1:0] r;
        logic [63:0]  x;
        logic [63:0]  y;
        logic [63:0]  d;
        logic [63:0]  v;
        r = '0;
        d = 64'(b[S-1:0]);
        for (int i = 0; i < LANES; i++) begin
            x = 64'(a[i*S +: S]);
            y = 64'(b[i*S +: S]);
            v = 64'd0;
            if (o) begin
                case (s)
                    2'b00: v = x * d;
                    2'b01: v = (d == 0) ? 64'hFFFF_FFFF : x / d;
                    2'b10: v = x + y;
                    default: v = x - y;
                endcase
            end else if (i == 0) begin
                case (s)
                    2'b00: v = x + y;
                    2'b01: v = x - y;
                    2'b10: v = x * y;
                    default: v = (y == 0) ? 64'hFFFF_FFFF : x / y;
                endcase
            end
            r[i*S +: S] = v[S-1:0];
        end
        return r;
    endfunction

    function automatic logic [LANES-1:0] modelLaneZero(input logic [V-1:0] c);
        logic [LANES-1:0] z;
        for (int i = 0; i < LANES; i++) begin
            z[i] = (c[i*S +: S] == '0);
        end
        return z;
    endfunction

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy) checkOutput("idle_timeout", V'(busy), V'(0));
    endtask

    // Launches one op, scrambles the inputs after capture, returns cycles to done.
    task automatic applyStimulus(input logic o, input logic [1:0] s, input logic [V-1:0] a,
                                 input logic [V-1:0] b, output int lat);
        waitIdle();
        op = o; sel = s; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; sel = ~s; A = randVec(); B = randVec();
        checkOutput("busy_after_start", V'(busy), V'(1));
        lat = 1;
        while (!done && lat < S + 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) checkOutput("done_timeout", V'(done), V'(1));
    endtask

    task automatic runOp(input string tag, input logic o, input logic [1:0] s,
                         input logic [V-1:0] a, input logic [V-1:0] b);
        int lat;
        logic [V-1:0] exp_c;
        logic is_div;
        is_div = o ? (s == 2'b01) : (s == 2'b11);
        exp_c  = modelResult(o, s, a, b);
        applyStimulus(o, s, a, b, lat);
        checkOutput({tag, "_lat"}, V'(lat), is_div ? V'(S + 2) : V'(2));
        checkOutput({tag, "_C"}, C, exp_c);
        checkOutput({tag, "_flagZ"}, V'(flagZ), V'(exp_c == '0));
        checkOutput({tag, "_lane_zero"}, V'(lane_zero), V'(modelLaneZero(exp_c)));
        checkOutput({tag, "_div0"}, V'(div0), V'(is_div && (b[S-1:0] == '0)));
    endtask

    initial begin
        logic [V-1:0] a;
        logic [V-1:0] b;
        logic [V-1:0] exp_c;
        logic [V-1:0] prev_c;
        int           done_seen;

        rst = 1'b1; start = 1'b0; op = 1'b0; sel = 2'b00; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_C", C, '0);
        checkOutput("reset_flagZ", V'(flagZ), V'(1));
        checkOutput("reset_lane_zero", V'(lane_zero), V'(6'b111111));
        checkOutput("reset_busy", V'(busy), V'(0));
        checkOutput("reset_done", V'(done), V'(0));
        checkOutput("reset_div0", V'(div0), V'(0));

        a = randVec(); b = randVec();
        a[S-1:0] = 32'd7; b[S-1:0] = 32'd7;
        runOp("sub_equal", 1'b0, 2'b01, a, b);

        a = {32'hFFFF_FFFF, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        b = {32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
        runOp("vadd_carry", 1'b1, 2'b10, a, b);

        a = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        b = randVec(); b[S-1:0] = 32'h0001_0000;
        runOp("smul", 1'b1, 2'b00, a, b);
        a[5*S +: S] = 32'h0001_0000;
        runOp("smul_trunc", 1'b1, 2'b00, a, b);

        a = {32'd1000, 32'd9, 32'd65, 32'd0, 32'd7, 32'd100};
        b = randVec(); b[S-1:0] = 32'd10;
        runOp("vdiv", 1'b1, 2'b01, a, b);
        b[S-1:0] = 32'd0;
        runOp("vdiv_zero", 1'b1, 2'b01, a, b);
        a = randVec(); b = randVec(); b[S-1:0] = 32'd0;
        runOp("sdiv_zero", 1'b0, 2'b11, a, b);

        // Abort a divide with reset and make sure it never completes.
        waitIdle();
        op = 1'b1; sel = 2'b01; A = randVec(); B = randVec(); B[S-1:0] = 32'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("abort_busy", V'(busy), V'(0));
        checkOutput("abort_C", C, '0);
        checkOutput("abort_flagZ", V'(flagZ), V'(1));
        checkOutput("abort_lane_zero", V'(lane_zero), V'(6'b111111));
        done_seen = 0;
        for (int i = 0; i < S + 8; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        checkOutput("abort_no_done", V'(done_seen), V'(0));

        // Start held high: accepted every third cycle, C moves only on done.
        waitIdle();
        a = randVec(); b = randVec();
        exp_c  = modelResult(1'b1, 2'b11, a, b);
        prev_c = C;
        op = 1'b1; sel = 2'b11; A = a; B = b; start = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("held_done_%0d", j), V'(done), V'((j % 3) == 2));
            if ((j % 3) == 2) begin
                checkOutput($sformatf("held_C_%0d", j), C, exp_c);
                prev_c = exp_c;
            end else begin
                checkOutput($sformatf("held_hold_%0d", j), C, prev_c);
            end
        end
        start = 1'b0;

        for (int n = 0; n < 40; n++) begin
            logic       o;
            logic [1:0] s;
            int         pick;
            o = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            a = randVec(); b = randVec();
            pick = $urandom_range(0, 3);
            if (pick == 0) b[S-1:0] = '0;
            else if (pick == 1) b[S-1:0] = $urandom_range(1, 300);
            runOp($sformatf("rand_%0d", n), o, s, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
